// File: rtl/hazard_tracking_unit.sv
// hazard_tracking_unit: ID-stage load-use stall, branch flush and EX/MEM/WB operand forwarding
// Ports: clk, reset_n (sync, active-low); ID_* describe the post-NOP-mux instruction in ID;
// EX_Taken flags a taken control transfer; CU_Mux_Sel/PC_LE/IF_ID_LE/IF_ID_Flush steer the
// front end; Fwd_A/Fwd_B pick 00 RF, 01 EX, 10 MEM, 11 WB; Stall_Count/Flush_Count saturate.
module hazard_tracking_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [4:0]       ID_rs1,
  input  logic [4:0]       ID_rs2,
  input  logic             ID_rs1_used,
  input  logic             ID_rs2_used,
  input  logic [4:0]       ID_rd,
  input  logic             ID_RF_Enable,
  input  logic             ID_Load_Instr,
  input  logic             EX_Taken,
  output logic             CU_Mux_Sel,
  output logic             PC_LE,
  output logic             IF_ID_LE,
  output logic             IF_ID_Flush,
  output logic [1:0]       Fwd_A,
  output logic [1:0]       Fwd_B,
  output logic [CNT_W-1:0] Stall_Count,
  output logic [CNT_W-1:0] Flush_Count
);
  typedef struct packed {
    logic       rf_en;
    logic       load;
    logic [4:0] rd;
  } slot_t;
  slot_t ex_s, mem_s, wb_s;
  logic stall, flush;
  // x0 is hardwired, so a write to it never produces a dependency
  function automatic logic writes(input slot_t s, input logic [4:0] r);
    return s.rf_en && s.rd == r && r != 5'd0;
  endfunction
  function automatic logic [1:0] fwd_sel(input slot_t e, input slot_t m, input slot_t w,
                                         input logic [4:0] r, input logic used);
    return !used ? 2'b00 : writes(e, r) ? 2'b01 : writes(m, r) ? 2'b10 : writes(w, r) ? 2'b11 : 2'b00;
  endfunction
  always_comb begin
    flush       = EX_Taken;
    stall       = ex_s.load && ((ID_rs1_used && writes(ex_s, ID_rs1)) ||
                                (ID_rs2_used && writes(ex_s, ID_rs2)));
    CU_Mux_Sel  = !reset_n || flush || stall;
    PC_LE       = reset_n && (flush || !stall);
    IF_ID_LE    = reset_n && (flush || !stall);
    IF_ID_Flush = reset_n && flush;
    Fwd_A       = reset_n ? fwd_sel(ex_s, mem_s, wb_s, ID_rs1, ID_rs1_used) : 2'b00;
    Fwd_B       = reset_n ? fwd_sel(ex_s, mem_s, wb_s, ID_rs2, ID_rs2_used) : 2'b00;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ex_s        <= '0;
      mem_s       <= '0;
      wb_s        <= '0;
      Stall_Count <= '0;
      Flush_Count <= '0;
    end else begin
      wb_s  <= mem_s;
      mem_s <= ex_s;
      ex_s  <= (stall || flush) ? slot_t'('0) : slot_t'({ID_RF_Enable, ID_Load_Instr, ID_rd});
      if (stall && !flush && !(&Stall_Count)) Stall_Count <= Stall_Count + CNT_W'(1);
      if (flush && !(&Flush_Count)) Flush_Count <= Flush_Count + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_hazard_tracking_unit.sv
// tb_hazard_tracking_unit: directed vectors for stall, flush, forwarding, reset and counter saturation
module tb_hazard_tracking_unit;
  localparam int CW = 4;
  logic clk = 0, reset_n = 0;
  logic [4:0] ID_rs1 = 0, ID_rs2 = 0, ID_rd = 0;
  logic ID_rs1_used = 0, ID_rs2_used = 0, ID_RF_Enable = 0, ID_Load_Instr = 0, EX_Taken = 0;
  logic CU_Mux_Sel, PC_LE, IF_ID_LE, IF_ID_Flush;
  logic [1:0] Fwd_A, Fwd_B;
  logic [CW-1:0] Stall_Count, Flush_Count;
  int nvec = 0, nerr = 0;
  hazard_tracking_unit #(.CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n), .ID_rs1(ID_rs1), .ID_rs2(ID_rs2),
    .ID_rs1_used(ID_rs1_used), .ID_rs2_used(ID_rs2_used), .ID_rd(ID_rd),
    .ID_RF_Enable(ID_RF_Enable), .ID_Load_Instr(ID_Load_Instr), .EX_Taken(EX_Taken),
    .CU_Mux_Sel(CU_Mux_Sel), .PC_LE(PC_LE), .IF_ID_LE(IF_ID_LE), .IF_ID_Flush(IF_ID_Flush),
    .Fwd_A(Fwd_A), .Fwd_B(Fwd_B), .Stall_Count(Stall_Count), .Flush_Count(Flush_Count)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic id(input logic [4:0] r1, input logic u1, input logic [4:0] r2, input logic u2,
                    input logic [4:0] rd, input logic rf, input logic ld, input logic tk);
    ID_rs1 = r1; ID_rs1_used = u1; ID_rs2 = r2; ID_rs2_used = u2;
    ID_rd = rd; ID_RF_Enable = rf; ID_Load_Instr = ld; EX_Taken = tk;
    #1;
  endtask
  task automatic drain();
    id(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) tick();
  endtask
  task automatic test_reset();
    id(5, 1, 6, 1, 5, 1, 1, 1);
    tick(); tick();
    nvec++;
    if ({CU_Mux_Sel, PC_LE, IF_ID_LE, IF_ID_Flush} !== 4'b1000) begin
      nerr++; $display("FAIL reset_ctl got %b exp 1000", {CU_Mux_Sel, PC_LE, IF_ID_LE, IF_ID_Flush});
    end
    nvec++;
    if ({Fwd_A, Fwd_B, Stall_Count, Flush_Count} !== '0) begin
      nerr++; $display("FAIL reset_fwd_cnt got %b/%b/%0d/%0d exp 0", Fwd_A, Fwd_B, Stall_Count, Flush_Count);
    end
    reset_n = 1;
    drain();
  endtask
  task automatic test_forward();
    id(0, 0, 0, 0, 5, 1, 0, 0);
    tick();
    id(5, 1, 0, 0, 0, 0, 0, 0);
    nvec++;
    if ({Fwd_A, CU_Mux_Sel, PC_LE} !== 4'b0101) begin
      nerr++; $display("FAIL fwd_ex got %b exp 0101", {Fwd_A, CU_Mux_Sel, PC_LE});
    end
    tick();
    id(5, 1, 5, 0, 0, 0, 0, 0);
    nvec++;
    if ({Fwd_A, Fwd_B} !== 4'b1000) begin
      nerr++; $display("FAIL fwd_mem got %b exp 1000", {Fwd_A, Fwd_B});
    end
    tick();
    nvec++;
    if (Fwd_A !== 2'b11) begin
      nerr++; $display("FAIL fwd_wb got %b exp 11", Fwd_A);
    end
    tick();
    nvec++;
    if (Fwd_A !== 2'b00) begin
      nerr++; $display("FAIL fwd_retired got %b exp 00", Fwd_A);
    end
  endtask
  task automatic test_load_use();
    id(0, 0, 0, 0, 7, 1, 1, 0);
    tick();
    id(0, 0, 7, 1, 9, 1, 0, 0);
    nvec++;
    if ({CU_Mux_Sel, PC_LE, IF_ID_LE, IF_ID_Flush, Stall_Count} !== {4'b1000, 4'd0}) begin
      nerr++; $display("FAIL lu_stall got %b cnt %0d exp 1000 cnt 0", {CU_Mux_Sel, PC_LE, IF_ID_LE, IF_ID_Flush}, Stall_Count);
    end
    tick();
    nvec++;
    if ({CU_Mux_Sel, PC_LE, IF_ID_LE, Fwd_B, Stall_Count} !== {3'b011, 2'b10, 4'd1}) begin
      nerr++; $display("FAIL lu_after got %b fwd %b cnt %0d exp 011 fwd 10 cnt 1", {CU_Mux_Sel, PC_LE, IF_ID_LE}, Fwd_B, Stall_Count);
    end
    drain();
  endtask
  task automatic test_x0();
    id(0, 0, 0, 0, 0, 1, 1, 0);
    tick();
    id(0, 1, 0, 1, 0, 0, 0, 0);
    nvec++;
    if ({Fwd_A, Fwd_B, CU_Mux_Sel, PC_LE} !== 6'b000001) begin
      nerr++; $display("FAIL x0_ex got %b exp 000001", {Fwd_A, Fwd_B, CU_Mux_Sel, PC_LE});
    end
    tick();
    nvec++;
    if ({Fwd_A, Fwd_B, Stall_Count} !== {4'b0000, 4'd1}) begin
      nerr++; $display("FAIL x0_mem got %b cnt %0d exp 0000 cnt 1", {Fwd_A, Fwd_B}, Stall_Count);
    end
    drain();
  endtask
  task automatic test_flush_priority();
    id(0, 0, 0, 0, 7, 1, 1, 0);
    tick();
    id(7, 1, 0, 0, 8, 1, 0, 1);
    nvec++;
    if ({CU_Mux_Sel, PC_LE, IF_ID_LE, IF_ID_Flush, Flush_Count} !== {4'b1111, 4'd0}) begin
      nerr++; $display("FAIL flush_ctl got %b cnt %0d exp 1111 cnt 0", {CU_Mux_Sel, PC_LE, IF_ID_LE, IF_ID_Flush}, Flush_Count);
    end
    tick();
    id(7, 1, 8, 1, 0, 0, 0, 0);
    nvec++;
    if ({Fwd_A, Fwd_B, CU_Mux_Sel, IF_ID_Flush} !== 6'b100000) begin
      nerr++; $display("FAIL flush_bubble got %b exp 100000", {Fwd_A, Fwd_B, CU_Mux_Sel, IF_ID_Flush});
    end
    nvec++;
    if ({Flush_Count, Stall_Count} !== {4'd1, 4'd1}) begin
      nerr++; $display("FAIL flush_cnt got %0d/%0d exp 1/1", Flush_Count, Stall_Count);
    end
    drain();
  endtask
  task automatic test_reset_mid_stall();
    id(0, 0, 0, 0, 3, 1, 1, 0);
    tick();
    id(3, 1, 0, 0, 0, 0, 0, 0);
    nvec++;
    if ({CU_Mux_Sel, PC_LE} !== 2'b10) begin
      nerr++; $display("FAIL rst_pre_stall got %b exp 10", {CU_Mux_Sel, PC_LE});
    end
    reset_n = 0;
    #1;
    tick();
    nvec++;
    if ({CU_Mux_Sel, PC_LE, IF_ID_LE, IF_ID_Flush, Fwd_A, Stall_Count, Flush_Count} !== {4'b1000, 2'b00, 4'd0, 4'd0}) begin
      nerr++; $display("FAIL rst_mid got %b fwd %b cnt %0d/%0d exp 1000 fwd 00 cnt 0/0", {CU_Mux_Sel, PC_LE, IF_ID_LE, IF_ID_Flush}, Fwd_A, Stall_Count, Flush_Count);
    end
    reset_n = 1;
    #1;
    nvec++;
    if ({Fwd_A, CU_Mux_Sel, PC_LE} !== 4'b0001) begin
      nerr++; $display("FAIL rst_release got %b exp 0001", {Fwd_A, CU_Mux_Sel, PC_LE});
    end
    tick();
    nvec++;
    if ({Fwd_A, Stall_Count} !== {2'b00, 4'd0}) begin
      nerr++; $display("FAIL rst_no_ghost got %b cnt %0d exp 00 cnt 0", Fwd_A, Stall_Count);
    end
    drain();
  endtask
  task automatic test_saturation();
    for (int i = 0; i < (1 << CW) + 3; i++) begin
      id(0, 0, 0, 0, 7, 1, 1, 0);
      tick();
      id(0, 0, 7, 1, 0, 0, 0, 0);
      tick();
      if (i == 13) begin
        nvec++;
        if (Stall_Count !== 4'd14) begin
          nerr++; $display("FAIL stall_cnt_14 got %0d exp 14", Stall_Count);
        end
      end
    end
    nvec++;
    if (Stall_Count !== 4'hf) begin
      nerr++; $display("FAIL stall_sat got %0d exp 15", Stall_Count);
    end
    id(0, 0, 0, 0, 0, 0, 0, 1);
    repeat ((1 << CW) + 1) tick();
    nvec++;
    if ({Flush_Count, Stall_Count} !== 8'hff) begin
      nerr++; $display("FAIL flush_sat got %0d/%0d exp 15/15", Flush_Count, Stall_Count);
    end
    drain();
  endtask
  initial begin
    test_reset();
    test_forward();
    test_load_use();
    test_x0();
    test_flush_priority();
    test_reset_mid_stall();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
